// File: rtl/fb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter_pkg
//  Description : Shared frame-buffer write geometry and clear-engine states.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_write_arbiter_pkg;

  localparam int FB_ADDR_W     = 19;
  localparam int FB_DATA_W     = 8;
  localparam int FB_NUM_PIXELS = 640 * 480;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter_if
//  Description : Processor write stream, clear command and frame-buffer
//                write port of the arbiter. master = requester side,
//                slave = arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface fb_write_arbiter_if
  import fb_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);

  logic              iCPU_WE;
  logic [ADDR_W-1:0] iCPU_ADDR;
  logic [DATA_W-1:0] iCPU_DATA;
  logic              oCPU_FULL;
  logic              oCPU_OVF;
  logic              iCLR_START;
  logic [DATA_W-1:0] iCLR_COLOR;
  logic              oCLR_BUSY;
  logic              oCLR_DONE;
  logic              oWE;
  logic [ADDR_W-1:0] oADDR;
  logic [DATA_W-1:0] oDATA;

  modport master (
    output iCPU_WE, iCPU_ADDR, iCPU_DATA, iCLR_START, iCLR_COLOR,
    input  oCPU_FULL, oCPU_OVF, oCLR_BUSY, oCLR_DONE, oWE, oADDR, oDATA
  );

  modport slave (
    input  iCPU_WE, iCPU_ADDR, iCPU_DATA, iCLR_START, iCLR_COLOR,
    output oCPU_FULL, oCPU_OVF, oCLR_BUSY, oCLR_DONE, oWE, oADDR, oDATA
  );

endinterface
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fb_wr_fifo
//  Description : Small synchronous FIFO buffering processor pixel writes.
//                A push while full is accepted only when a pop happens in
//                the same cycle (the freed slot is the one written).
//  Revision    : 1.0  initial release
// ============================================================================
module fb_wr_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  wire logic                       iCLK,
  input  wire logic                       iRST_n,
  input  wire logic                       iPUSH,
  input  wire logic                       iPOP,
  input  wire logic [WIDTH-1:0]           iDATA,
  output logic      [WIDTH-1:0]           oDATA,
  output logic      [$clog2(DEPTH+1)-1:0] oCOUNT,
  output logic                            oFULL,
  output logic                            oEMPTY
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign oFULL     = (r_count == c_CNT_W'(DEPTH));
  assign oEMPTY    = (r_count == '0);
  assign oCOUNT    = r_count;
  assign oDATA     = r_mem[r_rd_ptr];
  assign w_pop_ok  = iPOP && !oEMPTY;
  assign w_push_ok = iPUSH && (!oFULL || w_pop_ok);

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge iCLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= iDATA;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter
//  Description : Owns the frame-buffer write port. Shares it between the
//                buffered processor write stream and a full-screen clear
//                engine; the clear can be starved for at most STARVE_MAX
//                consecutive processor grants.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int NUM_PIXELS = FB_NUM_PIXELS,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input wire logic          iCLK,
  input wire logic          iRST_n,
  fb_write_arbiter_if.slave bus
);

  localparam logic [1:0]        c_ST_IDLE    = CLR_IDLE;
  localparam logic [1:0]        c_ST_RUN     = CLR_RUN;
  localparam logic [1:0]        c_ST_DONE    = CLR_DONE;
  localparam int                c_ENTRY_W    = ADDR_W + DATA_W;
  localparam int                c_CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int                c_STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);

  logic [1:0]            r_state;
  logic [ADDR_W-1:0]     r_clr_addr;
  logic [DATA_W-1:0]     r_clr_color;
  logic [c_STARVE_W-1:0] r_starve;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_ovf;

  logic [c_ENTRY_W-1:0]  w_fifo_rd;
  logic [c_CNT_W-1:0]    w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_in_run;
  logic                  w_grant_cpu;
  logic                  w_grant_clr;
  logic                  w_cpu_drop;

  fb_wr_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .iPUSH  (bus.iCPU_WE),
    .iPOP   (w_grant_cpu),
    .iDATA  ({bus.iCPU_ADDR, bus.iCPU_DATA}),
    .oDATA  (w_fifo_rd),
    .oCOUNT (w_fifo_count),
    .oFULL  (w_fifo_full),
    .oEMPTY (w_fifo_empty)
  );

  // Processor wins unless a clear is running and it has used its quota.
  assign w_in_run    = (r_state == c_ST_RUN);
  assign w_grant_cpu = !w_fifo_empty && (!w_in_run || (r_starve < c_STARVE_LIM));
  assign w_grant_clr = !w_grant_cpu && w_in_run;
  assign w_cpu_drop  = bus.iCPU_WE && w_fifo_full && !w_grant_cpu;

  assign bus.oWE       = r_we;
  assign bus.oADDR     = r_addr;
  assign bus.oDATA     = r_data;
  assign bus.oCPU_OVF  = r_ovf;
  assign bus.oCPU_FULL = (w_fifo_count == c_CNT_W'(FIFO_DEPTH));
  assign bus.oCLR_BUSY = (r_state == c_ST_RUN);
  assign bus.oCLR_DONE = (r_state == c_ST_DONE);

  // Clear engine: sweep every pixel once, then announce completion.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state     <= c_ST_IDLE;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.iCLR_START) begin
            r_clr_color <= bus.iCLR_COLOR;
            r_clr_addr  <= '0;
            r_state     <= c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          if (w_grant_clr) begin
            if (r_clr_addr == c_LAST_ADDR) begin
              r_state <= c_ST_DONE;
            end else begin
              r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Consecutive processor grants during a sweep; zero whenever not sweeping.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_starve <= '0;
    end else if (w_in_run && w_grant_cpu) begin
      r_starve <= r_starve + c_STARVE_W'(1);
    end else begin
      r_starve <= '0;
    end
  end

  // Registered write port; address/data hold their last value when idle.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_grant_cpu || w_grant_clr;
      if (w_grant_cpu) begin
        r_addr <= w_fifo_rd[c_ENTRY_W-1:DATA_W];
        r_data <= w_fifo_rd[DATA_W-1:0];
      end else if (w_grant_clr) begin
        r_addr <= r_clr_addr;
        r_data <= r_clr_color;
      end
    end
  end

  // Sticky record of any processor write lost to a full buffer.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_ovf <= 1'b0;
    end else if (w_cpu_drop) begin
      r_ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_write_arbiter
//  Description : Self-checking bench for fb_write_arbiter with a queue-based
//                reference model and directed plus randomized stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_write_arbiter;
  import fb_write_arbiter_pkg::*;

  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 8;
  localparam int NUM_PIX = 16;
  localparam int DEPTH   = 4;
  localparam int SMAX    = 8;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  fb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_write_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_PIXELS (NUM_PIX),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .iCLK   (CLOCK_50),
    .iRST_n (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              m_q[$];
  int                m_mode   = 0;   // 0 idle, 1 sweeping, 2 finished
  logic [ADDR_W-1:0] m_next   = '0;
  logic [DATA_W-1:0] m_color  = '0;
  int                m_starve = 0;
  logic              e_we = 0, e_full = 0, e_ovf = 0, e_busy = 0, e_done = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;
  bit                t_gc, t_gl, t_acc;
  int                t_nm;
  ent_t              t_item;

  // One arbitration step per clock from the rules, expressed with a queue.
  always @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_mode <= 0; m_next <= '0; m_color <= '0; m_starve <= 0;
      e_we <= 0; e_full <= 0; e_ovf <= 0; e_busy <= 0; e_done <= 0;
      e_addr <= '0; e_data <= '0;
    end else begin
      t_gc  = (m_q.size() > 0) && (m_mode != 1 || m_starve < SMAX);
      t_gl  = !t_gc && (m_mode == 1);
      t_acc = bus.iCPU_WE && (m_q.size() < DEPTH || t_gc);
      if (bus.iCPU_WE && !t_acc) e_ovf <= 1'b1;
      if (t_gc) begin
        t_item = m_q.pop_front();
        e_addr <= t_item.a;
        e_data <= t_item.d;
      end else if (t_gl) begin
        e_addr <= m_next;
        e_data <= m_color;
      end
      if (t_acc) m_q.push_back({bus.iCPU_ADDR, bus.iCPU_DATA});
      e_we     <= t_gc || t_gl;
      e_full   <= (m_q.size() == DEPTH);
      m_starve <= (m_mode == 1 && t_gc) ? m_starve + 1 : 0;
      t_nm = m_mode;
      if (m_mode == 0 && bus.iCLR_START) begin
        t_nm = 1; m_next <= '0; m_color <= bus.iCLR_COLOR;
      end else if (m_mode == 1 && t_gl) begin
        if (m_next == ADDR_W'(NUM_PIX - 1)) t_nm = 2;
        else m_next <= m_next + 1'b1;
      end else if (m_mode == 2) begin
        t_nm = 0;
      end
      m_mode <= t_nm;
      e_busy <= (t_nm == 1);
      e_done <= (t_nm == 2);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK_50) begin
    chk("oWE", bus.oWE, e_we);
    chk("oCPU_FULL", bus.oCPU_FULL, e_full);
    chk("oCPU_OVF", bus.oCPU_OVF, e_ovf);
    chk("oCLR_BUSY", bus.oCLR_BUSY, e_busy);
    chk("oCLR_DONE", bus.oCLR_DONE, e_done);
    if (e_we) begin
      chk("oADDR", bus.oADDR, e_addr);
      chk("oDATA", bus.oDATA, e_data);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, ".oWE"}, bus.oWE, 0);
    chk({tag, ".oADDR"}, bus.oADDR, 0);
    chk({tag, ".oDATA"}, bus.oDATA, 0);
    chk({tag, ".oCPU_FULL"}, bus.oCPU_FULL, 0);
    chk({tag, ".oCPU_OVF"}, bus.oCPU_OVF, 0);
    chk({tag, ".oCLR_BUSY"}, bus.oCLR_BUSY, 0);
    chk({tag, ".oCLR_DONE"}, bus.oCLR_DONE, 0);
  endtask

  // ---------------- stimulus ----------------
  int idx, we_cnt, done_cnt, run, max_run, clr_cnt, rate;
  bit full_seen;

  initial begin
    bus.iCPU_WE = 0; bus.iCPU_ADDR = '0; bus.iCPU_DATA = '0;
    bus.iCLR_START = 0; bus.iCLR_COLOR = '0;
    repeat (3) @(negedge CLOCK_50);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // Idle single write: visible exactly two edges after it is sampled.
    bus.iCPU_WE = 1; bus.iCPU_ADDR = 19'h00123; bus.iCPU_DATA = 8'h5A;
    @(negedge CLOCK_50);
    bus.iCPU_WE = 0;
    chk("single.we_n1", bus.oWE, 0);
    @(negedge CLOCK_50);
    chk("single.we_n2", bus.oWE, 1);
    chk("single.addr", bus.oADDR, 19'h00123);
    chk("single.data", bus.oDATA, 8'h5A);
    @(negedge CLOCK_50);
    chk("single.we_n3", bus.oWE, 0);
    chk("single.ovf", bus.oCPU_OVF, 0);

    // Full 16-pixel clear with no processor traffic.
    bus.iCLR_START = 1; bus.iCLR_COLOR = 8'h07;
    @(negedge CLOCK_50);
    bus.iCLR_START = 0;
    idx = 0; done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (bus.oWE) begin
        chk("clr.addr", bus.oADDR, idx);
        chk("clr.data", bus.oDATA, 8'h07);
        idx++;
      end
      if (bus.oCLR_DONE) begin
        done_cnt++;
        chk("clr.busy_at_done", bus.oCLR_BUSY, 0);
        chk("clr.addr_at_done", bus.oADDR, NUM_PIX - 1);
      end
    end
    chk("clr.writes", idx, 16);
    chk("clr.done_pulses", done_cnt, 1);

    // Fairness under constant processor traffic, plus an ignored restart.
    bus.iCLR_START = 1; bus.iCLR_COLOR = 8'h3C;
    @(negedge CLOCK_50);
    run = 0; max_run = 0; clr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 230; i++) begin
      bus.iCPU_WE    = (i < 27);
      bus.iCPU_ADDR  = ADDR_W'($urandom);
      bus.iCPU_DATA  = 8'h80 | 8'(i);
      bus.iCLR_START = (i == 13);
      bus.iCLR_COLOR = 8'hFF;
      @(negedge CLOCK_50);
      if (bus.oWE && bus.oDATA[7]) begin
        run++;
        if (run > max_run) max_run = run;
      end else if (bus.oWE) begin
        run = 0;
        if (bus.oDATA == 8'h3C) clr_cnt++;
      end
      if (bus.oCLR_DONE) done_cnt++;
    end
    bus.iCLR_START = 0;
    chk("fair.max_cpu_run", max_run, SMAX);
    chk("fair.clear_writes", clr_cnt, NUM_PIX);
    chk("fair.done_pulses", done_cnt, 1);
    chk("fair.no_ovf", bus.oCPU_OVF, 0);

    // Writes every cycle during a sweep eventually overflow the buffer.
    bus.iCLR_START = 1; bus.iCLR_COLOR = 8'h11;
    @(negedge CLOCK_50);
    bus.iCLR_START = 0;
    full_seen = 0;
    for (int i = 0; i < 60; i++) begin
      bus.iCPU_WE = 1; bus.iCPU_ADDR = ADDR_W'($urandom); bus.iCPU_DATA = 8'h80 | 8'(i);
      @(negedge CLOCK_50);
      if (bus.oCPU_FULL) full_seen = 1;
    end
    bus.iCPU_WE = 0;
    chk("ovf.full_seen", full_seen, 1);
    chk("ovf.sticky", bus.oCPU_OVF, 1);
    chk("ovf.busy", bus.oCLR_BUSY, 1);
    chk("ovf.full_pre_reset", bus.oCPU_FULL, 1);

    // Asynchronous reset mid-sweep with a loaded FIFO.
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    we_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      if (bus.oWE) we_cnt++;
      if (bus.oCLR_DONE) done_cnt++;
    end
    chk("post_rst.we", we_cnt, 0);
    chk("post_rst.done", done_cnt, 0);
    chk("post_rst.busy", bus.oCLR_BUSY, 0);

    // Randomized traffic with varying write density; model checks each cycle.
    for (int c = 0; c < 3000; c++) begin
      case (c / 500)
        0: rate = 30;
        1: rate = 95;
        2: rate = 100;
        3: rate = 60;
        4: rate = 10;
        default: rate = 85;
      endcase
      bus.iCPU_WE    = ($urandom_range(0, 99) < rate);
      bus.iCPU_ADDR  = ADDR_W'($urandom);
      bus.iCPU_DATA  = 8'($urandom);
      bus.iCLR_START = ($urandom_range(0, 59) == 0);
      bus.iCLR_COLOR = 8'($urandom);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge CLOCK_50);
    end
    bus.iCPU_WE = 0; bus.iCLR_START = 0;
    repeat (5) @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
